// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divider issue controller: FSM encoding, defaults, helpers.
// Pure package; no timing or flow control of its own.
package div_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_WB    = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam int TAGW_DEF    = 4;
  localparam int DIV_LATENCY = 23;

  // Round-robin successor: slot after idx, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr_i, with wrap.
// Zero latency; no backpressure, the caller gates grant_o when it cannot accept.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [PW-1:0]   idx_o,
  output logic            vld_o
);

  int unsigned cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    vld_o   = 1'b0;
    cand    = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(ptr_i) + i) % NREQ;
      if (!vld_o && req_i[cand]) begin
        vld_o         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issues one RS divide at a time to the shared divider, holds operands until div_done, then drives the CDB.
// Grant is combinational in IDLE; the result waits in WB until cdb_ready; flush squashes, timeout sets sticky err.
module div_issue_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int TAGW    = TAGW_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic [NREQ-1:0]      req_grant,
  output logic                 div_in_valid,
  output logic [31:0]          div_a,
  output logic [31:0]          div_b,
  input  logic                 div_done,
  input  logic [31:0]          div_res,
  output logic                 cdb_valid,
  output logic [TAGW-1:0]      cdb_tag,
  output logic [31:0]          cdb_data,
  input  logic                 cdb_ready,
  input  logic                 flush,
  output logic                 busy,
  output logic                 err
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  logic [1:0]      state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            div_in_valid_q, div_in_valid_d;
  logic [31:0]     div_a_q, div_a_d;
  logic [31:0]     div_b_q, div_b_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic            cdb_valid_q, cdb_valid_d;
  logic [TAGW-1:0] cdb_tag_q, cdb_tag_d;
  logic [31:0]     cdb_data_q, cdb_data_d;

  logic [NREQ-1:0] arb_grant;
  logic [PW-1:0]   arb_idx;
  logic            arb_vld;
  logic            grant_en;
  logic            timeout;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .vld_o   (arb_vld)
  );

  assign grant_en  = rst_n && !flush && (state_q == ST_IDLE);
  assign req_grant = grant_en ? arb_grant : '0;
  assign timeout   = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    div_in_valid_d = div_in_valid_q;
    div_a_d        = div_a_q;
    div_b_d        = div_b_q;
    tag_d          = tag_q;
    cdb_valid_d    = cdb_valid_q;
    cdb_tag_d      = cdb_tag_q;
    cdb_data_d     = cdb_data_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_en && arb_vld) begin
          div_a_d        = req_a[32*arb_idx +: 32];
          div_b_d        = req_b[32*arb_idx +: 32];
          tag_d          = req_tag[TAGW*arb_idx +: TAGW];
          div_in_valid_d = 1'b1;
          cnt_d          = '0;
          rr_ptr_d       = PW'(rr_next(int'(arb_idx), NREQ));
          state_d        = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        // A flush that coincides with completion drops the result outright.
        if (div_done && flush) begin
          div_in_valid_d = 1'b0;
          state_d        = ST_IDLE;
        end else if (div_done) begin
          cdb_valid_d    = 1'b1;
          cdb_tag_d      = tag_q;
          cdb_data_d     = div_res;
          div_in_valid_d = 1'b0;
          state_d        = ST_WB;
        end else if (timeout) begin
          err_d          = 1'b1;
          div_in_valid_d = 1'b0;
          state_d        = ST_IDLE;
        end else if (flush) begin
          div_in_valid_d = 1'b0;
          state_d        = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (div_done) begin
          state_d = ST_IDLE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WB: begin
        if (flush || cdb_ready) begin
          cdb_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      rr_ptr_q       <= '0;
      cnt_q          <= '0;
      err_q          <= 1'b0;
      div_in_valid_q <= 1'b0;
      div_a_q        <= '0;
      div_b_q        <= '0;
      tag_q          <= '0;
      cdb_valid_q    <= 1'b0;
      cdb_tag_q      <= '0;
      cdb_data_q     <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      cnt_q          <= cnt_d;
      err_q          <= err_d;
      div_in_valid_q <= div_in_valid_d;
      div_a_q        <= div_a_d;
      div_b_q        <= div_b_d;
      tag_q          <= tag_d;
      cdb_valid_q    <= cdb_valid_d;
      cdb_tag_q      <= cdb_tag_d;
      cdb_data_q     <= cdb_data_d;
    end
  end

  assign div_in_valid = div_in_valid_q;
  assign div_a        = div_a_q;
  assign div_b        = div_b_q;
  assign cdb_valid    = cdb_valid_q;
  assign cdb_tag      = cdb_tag_q;
  assign cdb_data     = cdb_data_q;
  assign busy         = (state_q != ST_IDLE);
  assign err          = err_q;

endmodule
